fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Read-side engine for the synchronous FIFO. It drains the FIFO through its rd_en/EMPTY/data_out interface and presents the words as a valid/ready stream to a downstream consumer. A 2-entry skid buffer hides the FIFO's 1-cycle read latency, so the block sustains one word per clock while m_ready stays high. Words are delivered in FIFO order and never duplicated.

Parameters:
DATA_WIDTH, 6, width of FIFO words and of m_data
CNT_WIDTH, 16, width of the delivered-word counter (used only with the optional feature)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous reset, active-low
fifo_empty  input  1  EMPTY flag from the FIFO
fifo_rd_en  output  1  read strobe to the FIFO
fifo_data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after a rd_en accepted while !EMPTY
m_valid  output  1  stream data valid
m_data  output  DATA_WIDTH  stream data, the head of the skid buffer
m_ready  input  1  consumer accepts m_data when m_valid && m_ready
flush  input  1  synchronous drop of all buffered and in-flight words
word_cnt  output  CNT_WIDTH  delivered-word count (present only with STREAM_READER_STATS_EN)

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: occ=0, inflight=0, m_valid=0, m_data=0, word_cnt=0.
  - fifo_rd_en is 0 while rst_n=0.
- State:
  - occ (0..2): number of words held in the skid buffer.
  - inflight (1 bit): fifo_rd_en was issued in the previous cycle.
- pop = m_valid && m_ready.
- fifo_rd_en is combinational: !fifo_empty && !flush && ((occ + inflight < 2) || pop).
  - The m_ready-to-fifo_rd_en path is combinational by design; it is what gives full throughput.
- inflight_next = fifo_rd_en.
- Landing: when inflight=1, fifo_data_out is written to skid entry index (occ - pop).
  - occ_next = occ + inflight - pop.
  - Invariant: occ + inflight <= 2. Any violation is a design bug.
- Output:
  - m_valid = (occ != 0).
  - m_data = entry[0].
  - On pop, entry[1] shifts into entry[0].
  - m_data holds its value while m_valid && !m_ready.
- Latency: first word reaches m_valid 2 cycles after fifo_empty deasserts (rd_en cycle, landing cycle, then registered m_valid).
- Steady state with m_ready=1 and a non-empty FIFO: one word per cycle, with occ=1 and inflight=1.
- Back-pressure (m_ready=0): occ fills to 2, then fifo_rd_en holds at 0. No word is lost and none is reordered.
- fifo_empty mid-stream: fifo_rd_en drops in the same cycle. Buffered words keep draining.
- flush=1:
  - occ_next=0 and inflight_next=0.
  - Any word landing in that cycle is discarded.
  - fifo_rd_en is forced to 0.
  - A word read from the FIFO in the previous cycle is lost. This is intentional.
- Simultaneous landing, pop and rd_en in the same cycle are all legal and must all be honoured.
- Reset asserted mid-stream: immediate return to reset values. The FIFO is reset independently.

Optional Feature:
STREAM_READER_STATS_EN
- Defined:
  - word_cnt increments by 1 on every pop and wraps at 2^CNT_WIDTH.
  - word_cnt is not cleared by flush; only rst_n clears it.
- Undefined: the word_cnt port and its counter logic do not exist.

Decomposition:
- Shared package fifo_pkg holds:
  - the DATA_WIDTH default (6);
  - localparam SKID_DEPTH = 2;
  - the occupancy type (2-bit);
  - the CNT_WIDTH default.
- One natural sub-module, reader_skid_buf: 2-entry buffer with write-index/landing, shift-on-pop and the occ counter.
- Top level contains: the rd_en decision, the inflight flop, flush handling and the optional counter.

Test Plan:
- Reset mid-stream (rst_n low at an arbitrary cycle) -> fifo_rd_en=0, m_valid=0, word_cnt=0 immediately.
- Write 8 words (0x2A, 0x15, 0x01, 0x02, 0x04, 0x08, 0x10, 0x20) into the FIFO, m_ready=1 -> m_data shows the same sequence on 8 consecutive cycles; first m_valid 2 cycles after EMPTY falls.
- Same 8 words, m_ready=0 for 10 cycles, then 1 -> fifo_rd_en pulses exactly twice, occ holds at 2, then all 8 words arrive in order with none repeated.
- Toggle m_ready every cycle -> every word is delivered exactly once, and m_data is stable while m_valid && !m_ready.
- FIFO holds 0x21, 0x10, 0x08; pulse flush one cycle after the first rd_en -> m_valid drops the next cycle, and the next delivered word is 0x08.
- With STREAM_READER_STATS_EN defined, CNT_WIDTH=4, deliver 18 words -> word_cnt=2.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, skid depth and occupancy type for the FIFO read engine
package fifo_pkg;
  localparam int DATA_WIDTH_DEFAULT = 6;
  localparam int CNT_WIDTH_DEFAULT  = 16;
  localparam int SKID_DEPTH         = 2;

  typedef logic [1:0] occ_t;
endpackage

// File: rtl/reader_skid_buf.sv
// rtl/reader_skid_buf.sv - 2-entry skid buffer: landing at occ-pop, shift-on-pop, occupancy counter
module reader_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  land,
  input  logic [DATA_WIDTH-1:0] land_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] entry [SKID_DEPTH];
  logic                  land_idx;

  // Landing slot accounts for the head leaving in the same cycle.
  assign land_idx = ((occ - occ_t'(pop)) == occ_t'(1));
  assign head     = entry[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= '0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (pop) entry[0] <= entry[1];
      // Placed after the shift so a landing into slot 0 wins over stale entry[1].
      if (land) entry[land_idx] <= land_data;
      if (clear) occ <= '0;
      else       occ <= occ + occ_t'(land) - occ_t'(pop);
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read engine to valid/ready stream; STREAM_READER_STATS_EN adds word_cnt
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
`ifdef STREAM_READER_STATS_EN
  , parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush
`ifdef STREAM_READER_STATS_EN
  , output logic [CNT_WIDTH-1:0] word_cnt
`endif
);
  logic [1:0] occ;
  logic       inflight;
  logic       pop;
  logic       land;
  logic [2:0] pending;

  assign pop     = m_valid & m_ready;
  assign pending = {1'b0, occ} + {2'b0, inflight};

  // A pop frees a slot this cycle, so m_ready feeds rd_en directly for full throughput.
  assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & ((pending < 3'd2) | pop);
  assign land       = inflight & ~flush;
  assign m_valid    = (occ != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  reader_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .land      (land),
    .land_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  // Buffered plus in-flight words must never exceed the skid depth.
  assert property (@(posedge clk) disable iff (!rst_n) pending <= 3'(SKID_DEPTH));

`ifdef STREAM_READER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
  end
`endif
endmodule
